// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one external combinational ALU between two
// valid/ready requesters with round-robin arbitration and returns the
// captured result on a shared valid/ready response port tagged with the id.
//
// state | meaning
// IDLE  | waiting for a command; the granted requester sees ready
// ISSUE | operands registered on the ALU inputs, result settling
// RESP  | response presented, held until rsp_ready
module alu_share_arbiter #(
    parameter int DATA_W = 4,
    parameter int FN_W   = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [FN_W-1:0]   req0_fn,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [FN_W-1:0]   req1_fn,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [FN_W-1:0]   alu_fn,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_id,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  op_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_prio;
    logic   w_grant_id;
    logic   w_accept;
    logic   w_rsp_done;

    // Grant selection: a lone valid requester wins, a tie goes to prio.
    always_comb begin
        w_grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant_id = r_prio;
        end else if (req1_valid) begin
            w_grant_id = 1'b1;
        end
    end

    // Readies only in IDLE; gated by rst_n so they read 0 while reset is held.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (rst_n && (r_state == IDLE)) begin
            req0_ready = req0_valid && !w_grant_id;
            req1_ready = req1_valid &&  w_grant_id;
        end
    end

    assign w_accept   = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign w_rsp_done = (r_state == RESP) && rsp_valid && rsp_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)   w_state_nxt = ISSUE;
            ISSUE:                   w_state_nxt = RESP;
            RESP:    if (w_rsp_done) w_state_nxt = IDLE;
            default:                 w_state_nxt = IDLE;
        endcase
    end

    // Operand capture on accept; prio flips away from the winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_fn <= '0;
            rsp_id <= 1'b0;
            r_prio <= 1'b0;
        end else if (w_accept) begin
            alu_a  <= w_grant_id ? req1_a  : req0_a;
            alu_b  <= w_grant_id ? req1_b  : req0_b;
            alu_fn <= w_grant_id ? req1_fn : req0_fn;
            rsp_id <= w_grant_id;
            r_prio <= ~w_grant_id;
        end
    end

    // Response capture at the end of ISSUE, release and count on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            op_count  <= '0;
        end else if (r_state == ISSUE) begin
            rsp_valid <= 1'b1;
            rsp_data  <= alu_result;
            rsp_err   <= (alu_fn > FN_W'(4));
        end else if (w_rsp_done) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: models the external ALU, drives directed and
// random commands, and checks each transaction against a transaction-level
// reference (round-robin prio, arithmetic result, response count).
module tb_alu_share_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0] req0_fn = '0, req1_fn = '0;
    logic [3:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_fn;
    logic       rsp_valid, rsp_ready = 1'b0;
    logic [3:0] rsp_data;
    logic       rsp_id, rsp_err;
    logic [7:0] op_count;

    int total = 0;
    int bad = 0;

    // Reference state: whose turn on a tie, and responses completed.
    bit m_prio = 1'b0;
    int m_count = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_W(4), .FN_W(3), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_fn(req0_fn),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_fn(req1_fn),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .op_count(op_count)
    );

    // External combinational ALU.
    always_comb begin
        case (alu_fn)
            3'd0:    alu_result = alu_a + alu_b;
            3'd1:    alu_result = alu_a - alu_b;
            3'd2:    alu_result = alu_a & alu_b;
            3'd3:    alu_result = alu_a | alu_b;
            3'd4:    alu_result = alu_a ^ alu_b;
            default: alu_result = 4'd0;
        endcase
    end

    // Expected response value from plain integer arithmetic.
    function automatic int ref_result(int a, int b, int fn);
        case (fn)
            0:       return (a + b) % 16;
            1:       return (a - b + 16) % 16;
            2:       return a & b;
            3:       return a | b;
            4:       return a ^ b;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".req0_ready"}, int'(req0_ready), 0);
        chk({tag, ".req1_ready"}, int'(req1_ready), 0);
        chk({tag, ".alu_a"},      int'(alu_a), 0);
        chk({tag, ".alu_b"},      int'(alu_b), 0);
        chk({tag, ".alu_fn"},     int'(alu_fn), 0);
        chk({tag, ".rsp_valid"},  int'(rsp_valid), 0);
        chk({tag, ".rsp_data"},   int'(rsp_data), 0);
        chk({tag, ".rsp_id"},     int'(rsp_id), 0);
        chk({tag, ".rsp_err"},    int'(rsp_err), 0);
        chk({tag, ".op_count"},   int'(op_count), 0);
    endtask

    // One full command -> response transaction. keep holds the valids high
    // while busy; stall is the number of RESP cycles with rsp_ready low.
    task automatic run_op(input bit v0, input bit v1,
                          input int a0, input int b0, input int f0,
                          input int a1, input int b1, input int f1,
                          input int stall, input bit keep);
        int g, ea, eb, ef, exp_d;
        @(negedge clk);
        req0_valid = v0; req0_a = a0[3:0]; req0_b = b0[3:0]; req0_fn = f0[2:0];
        req1_valid = v1; req1_a = a1[3:0]; req1_b = b1[3:0]; req1_fn = f1[2:0];
        rsp_ready = 1'b0;
        g = (v0 && v1) ? int'(m_prio) : (v1 ? 1 : 0);
        ea = g ? a1 : a0; eb = g ? b1 : b0; ef = g ? f1 : f0;
        exp_d = ref_result(ea, eb, ef);
        #1;
        chk("grant.ready0", int'(req0_ready), (g == 0) ? 1 : 0);
        chk("grant.ready1", int'(req1_ready), (g == 1) ? 1 : 0);
        @(posedge clk); #1;
        if (!keep) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
        end
        chk("issue.alu_a", int'(alu_a), ea);
        chk("issue.alu_b", int'(alu_b), eb);
        chk("issue.alu_fn", int'(alu_fn), ef);
        chk("issue.rsp_valid", int'(rsp_valid), 0);
        chk("issue.ready0", int'(req0_ready), 0);
        chk("issue.ready1", int'(req1_ready), 0);
        @(posedge clk); #1;
        chk("resp.rsp_valid", int'(rsp_valid), 1);
        chk("resp.rsp_data", int'(rsp_data), exp_d);
        chk("resp.rsp_id", int'(rsp_id), g);
        chk("resp.rsp_err", int'(rsp_err), (ef > 4) ? 1 : 0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("stall.rsp_valid", int'(rsp_valid), 1);
            chk("stall.rsp_data", int'(rsp_data), exp_d);
            chk("stall.ready0", int'(req0_ready), 0);
            chk("stall.ready1", int'(req1_ready), 0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        m_count = (m_count + 1) % 256;
        m_prio = (g == 0);
        chk("done.rsp_valid", int'(rsp_valid), 0);
        chk("done.op_count", int'(op_count), m_count);
        chk("done.alu_a_held", int'(alu_a), ea);
        if (!keep) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        m_prio = 1'b0;
        m_count = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Power-on reset with both requesters asserting valid.
        req0_valid = 1'b1; req1_valid = 1'b1;
        #12;
        chk_all_zero("por");
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester ADD: 3 + 5 = 8, id 0, count 1.
        run_op(1, 0, 3, 5, 0, 0, 0, 0, 0, 0);

        // Reset while a response is waiting in RESP.
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 4'd7; req0_b = 4'd1; req0_fn = 3'd0;
        req1_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mid.rsp_valid_before", int'(rsp_valid), 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        m_prio = 1'b0;
        m_count = 0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Both valid every cycle: grants alternate 0,1,0,1; SUB 2-3 wraps to F.
        run_op(1, 1, 1, 1, 0, 2, 3, 1, 0, 1);
        run_op(1, 1, 6, 3, 2, 2, 3, 1, 0, 1);
        run_op(1, 1, 4, 8, 3, 2, 3, 1, 0, 1);
        run_op(1, 1, 9, 9, 4, 2, 3, 1, 0, 1);

        // Response back-pressure for 5 cycles.
        run_op(0, 1, 0, 0, 0, 12, 7, 0, 5, 1);

        // Illegal function gives 0 with err, then XOR A^5 = F.
        run_op(1, 0, 9, 9, 6, 0, 0, 0, 0, 0);
        run_op(0, 1, 0, 0, 0, 10, 5, 4, 0, 0);

        // 256 random back-to-back ops from reset: op_count wraps to 0.
        apply_reset();
        for (int n = 0; n < 256; n++) begin
            bit v0, v1;
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            run_op(v0, v1,
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end
        chk("wrap.op_count", int'(op_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
